// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg
// Shared definitions for the multi-cycle core sequencer: state encodings,
// RV32I major opcodes, writeback/PC mux select codes and the default
// memory timeout, plus small opcode classification helpers.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    RESET_S = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    TRAP    = 3'd6
  } state_t;

  localparam logic [6:0] OPCODE_R    = 7'b0110011;
  localparam logic [6:0] OPCODE_I    = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI  = 7'b0110111;
  localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;
  localparam logic [6:0] OPCODE_S    = 7'b0100011;
  localparam logic [6:0] OPCODE_L    = 7'b0000011;
  localparam logic [6:0] OPCODE_B    = 7'b1100011;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_IMM  = 2'd1;
  localparam logic [1:0] PC_SEL_ALU  = 2'd2;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OPCODE_R, OPCODE_I, OPCODE_LUI, OPCODE_JAL,
      OPCODE_JALR, OPCODE_S, OPCODE_L, OPCODE_B: opcode_legal = 1'b1;
      default:                                   opcode_legal = 1'b0;
    endcase
  endfunction

  function automatic logic opcode_is_mem(input logic [6:0] op);
    opcode_is_mem = (op == OPCODE_L) || (op == OPCODE_S);
  endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// wait_timer
// Request wait counter shared by instruction fetch and data access.
// Counts request cycles that saw no ack; final_cycle flags the last cycle
// in which an ack is still accepted (count == TIMEOUT-1). A request with
// no ack in that cycle would push the count to TIMEOUT, which is the fault.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clr          : hold the count at zero (asserted outside wait states)
//   inc          : a request cycle passed without ack
//   final_cycle  : count has reached TIMEOUT-1
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic final_cycle
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  assign final_cycle = (cnt == W'(TIMEOUT - 1));

  // Never counts past TIMEOUT-1: the sequencer leaves the wait state
  // (ack or fault) on that cycle, so the count cannot overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !final_cycle) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
// Multi-cycle control FSM stepping the single-issue RISC-V core through
// FETCH, DECODE, EXECUTE, MEM and WB. Drives the instruction/data memory
// handshakes and all IR, register-file and PC write strobes, counts retired
// instructions, and halts on an illegal opcode or a memory ack timeout.
//
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   imem_req / imem_ack         : instruction fetch handshake
//   ir_we                       : instruction register load (fetch ack cycle)
//   opcode, writeback,
//   mem_write_enable            : decoder outputs from the registered IR
//   branch_taken                : ALU compare result, sampled in EXECUTE
//   dmem_req / dmem_we / dmem_ack : data memory handshake
//   rf_we, wb_sel               : register-file write strobe and source
//   pc_we, pc_sel               : PC update strobe and source
//   halt, illegal, bus_err      : stopped, and sticky halt cause
//   instret                     : retired instruction counter
//   state                       : current FSM state, debug only
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  input  logic [6:0]       opcode,
  input  logic             writeback,
  input  logic             mem_write_enable,
  input  logic             branch_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             halt,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  state_t           state_q, state_d;
  logic             take_q;
  logic             illegal_q, bus_err_q;
  logic             set_illegal, set_bus_err;
  logic [CNT_W-1:0] instret_q;
  logic             waiting, acked, final_cycle;
  logic             no_rf_write;

  assign waiting = (state_q == FETCH) || (state_q == MEM);
  assign acked   = ((state_q == FETCH) && imem_ack) ||
                   ((state_q == MEM)   && dmem_ack);

  // Held clear outside FETCH/MEM, so each entry starts counting from zero.
  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (!waiting),
    .inc         (waiting && !acked),
    .final_cycle (final_cycle)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RESET_S;
      take_q    <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXECUTE) take_q    <= branch_taken;
      if (set_illegal)        illegal_q <= 1'b1;
      if (set_bus_err)        bus_err_q <= 1'b1;
      if (state_q == WB)      instret_q <= instret_q + 1'b1;
    end
  end

  assign no_rf_write = (opcode == OPCODE_S) || (opcode == OPCODE_B);

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    halt        = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state_q)
      RESET_S: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (final_cycle) begin
          set_bus_err = 1'b1;
          state_d     = TRAP;
        end
      end
      DECODE: begin
        if (opcode_legal(opcode)) begin
          state_d = EXECUTE;
        end else begin
          set_illegal = 1'b1;
          state_d     = TRAP;
        end
      end
      EXECUTE: state_d = opcode_is_mem(opcode) ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write_enable;
        if (dmem_ack) begin
          state_d = WB;
        end else if (final_cycle) begin
          set_bus_err = 1'b1;
          state_d     = TRAP;
        end
      end
      WB: begin
        rf_we   = writeback && !no_rf_write;
        pc_we   = 1'b1;
        state_d = FETCH;
      end
      TRAP: halt = 1'b1;
      default: state_d = RESET_S;
    endcase
  end

  // Mux selects follow the current opcode; only consumed while in WB.
  always_comb begin
    wb_sel = WB_SEL_ALU;
    pc_sel = PC_SEL_PC4;
    case (opcode)
      OPCODE_L:    wb_sel = WB_SEL_LOAD;
      OPCODE_JAL: begin
        wb_sel = WB_SEL_PC4;
        pc_sel = PC_SEL_IMM;
      end
      OPCODE_JALR: begin
        wb_sel = WB_SEL_PC4;
        pc_sel = PC_SEL_ALU;
      end
      OPCODE_B:    pc_sel = take_q ? PC_SEL_IMM : PC_SEL_PC4;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
// Directed plus randomized instruction streams against a per-instruction
// reference model of the sequencer's observable behaviour.
module tb_cpu_sequencer;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;

  localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC  = 3'd3, S_MEM   = 3'd4, S_WB     = 3'd5,
                         S_TRAP  = 3'd6;

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LUI = 7'h37,
                         OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_S = 7'h23,
                         OP_L = 7'h03, OP_B = 7'h63;

  logic             clk;
  logic             rst_n;
  logic             imem_req, imem_ack, ir_we;
  logic [6:0]       opcode;
  logic             writeback, mem_write_enable, branch_taken;
  logic             dmem_req, dmem_we, dmem_ack;
  logic             rf_we, pc_we;
  logic [1:0]       wb_sel, pc_sel;
  logic             halt, illegal, bus_err;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state;

  int checks;
  int failures;
  int exp_instret;

  cpu_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_ack         (imem_ack),
    .ir_we            (ir_we),
    .opcode           (opcode),
    .writeback        (writeback),
    .mem_write_enable (mem_write_enable),
    .branch_taken     (branch_taken),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_ack         (dmem_ack),
    .rf_we            (rf_we),
    .wb_sel           (wb_sel),
    .pc_we            (pc_we),
    .pc_sel           (pc_sel),
    .halt             (halt),
    .illegal          (illegal),
    .bus_err          (bus_err),
    .instret          (instret),
    .state            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rules, one instruction at a time.
  function automatic logic m_is_mem(input logic [6:0] op);
    return (op == OP_L) || (op == OP_S);
  endfunction

  function automatic logic [1:0] m_wb_sel(input logic [6:0] op);
    if (op == OP_L) return 2'd1;
    if (op == OP_JAL || op == OP_JALR) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_pc_sel(input logic [6:0] op, input logic take);
    if (op == OP_JAL) return 2'd1;
    if (op == OP_B) return take ? 2'd1 : 2'd0;
    if (op == OP_JALR) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_rf_we(input logic [6:0] op, input logic wbk);
    if (op == OP_S || op == OP_B) return 1'b0;
    return wbk;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_state", 64'(state), 64'(S_RESET));
    chk("rst_strobes", 64'({imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we}), 64'd0);
    chk("rst_flags", 64'({halt, illegal, bus_err}), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    rst_n       = 1'b1;
    exp_instret = 0;
  endtask

  // fault: 0 = completes, 1 = fetch never acked, 2 = data access never acked.
  // iw/dw: no-ack cycles before the ack (0 .. TIMEOUT-1).
  task automatic run_instr(input logic [6:0] op, input logic wbk, input logic mwe,
                           input logic br, input int iw, input int dw, input int fault);
    int nf;
    int nm;
    nf = (fault == 1) ? TIMEOUT : iw + 1;
    for (int k = 0; k < nf; k++) begin
      @(negedge clk);
      imem_ack = (fault != 1) && (k == iw);
      dmem_ack = rbit();
      #1;
      chk("fetch_state", 64'(state), 64'(S_FETCH));
      chk("fetch_imem_req", 64'(imem_req), 64'd1);
      chk("fetch_ir_we", 64'(ir_we), 64'((fault != 1) && (k == iw)));
      chk("fetch_dmem_req", 64'(dmem_req), 64'd0);
      if (k == 0) chk("instret", 64'(instret), 64'(exp_instret));
    end
    if (fault == 1) begin
      @(negedge clk);
      imem_ack = 1'b1;
      #1;
      chk("ftmo_state", 64'(state), 64'(S_TRAP));
      chk("ftmo_flags", 64'({halt, illegal, bus_err}), 64'b101);
      chk("ftmo_strobes", 64'({imem_req, ir_we, rf_we, pc_we}), 64'd0);
      return;
    end

    @(negedge clk);
    imem_ack         = rbit();
    dmem_ack         = rbit();
    opcode           = op;
    writeback        = wbk;
    mem_write_enable = mwe;
    branch_taken     = ~br;
    #1;
    chk("decode_state", 64'(state), 64'(S_DECODE));
    chk("decode_strobes", 64'({imem_req, ir_we, dmem_req, rf_we, pc_we}), 64'd0);

    @(negedge clk);
    branch_taken = br;
    imem_ack     = rbit();
    dmem_ack     = rbit();
    #1;
    chk("exec_state", 64'(state), 64'(S_EXEC));
    chk("exec_strobes", 64'({imem_req, dmem_req, rf_we, pc_we}), 64'd0);

    if (m_is_mem(op)) begin
      nm = (fault == 2) ? TIMEOUT : dw + 1;
      for (int k = 0; k < nm; k++) begin
        @(negedge clk);
        branch_taken = ~br;
        imem_ack     = rbit();
        dmem_ack     = (fault != 2) && (k == dw);
        #1;
        chk("mem_state", 64'(state), 64'(S_MEM));
        chk("mem_dmem_req", 64'(dmem_req), 64'd1);
        chk("mem_dmem_we", 64'(dmem_we), 64'(mwe));
        chk("mem_imem_req", 64'(imem_req), 64'd0);
      end
      if (fault == 2) begin
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        chk("dtmo_state", 64'(state), 64'(S_TRAP));
        chk("dtmo_flags", 64'({halt, illegal, bus_err}), 64'b101);
        chk("dtmo_strobes", 64'({dmem_req, dmem_we, rf_we, pc_we}), 64'd0);
        return;
      end
    end

    @(negedge clk);
    branch_taken = ~br;
    imem_ack     = rbit();
    dmem_ack     = rbit();
    #1;
    chk("wb_state", 64'(state), 64'(S_WB));
    chk("wb_rf_we", 64'(rf_we), 64'(m_rf_we(op, wbk)));
    chk("wb_pc_we", 64'(pc_we), 64'd1);
    chk("wb_wb_sel", 64'(wb_sel), 64'(m_wb_sel(op)));
    chk("wb_pc_sel", 64'(pc_sel), 64'(m_pc_sel(op, br)));
    chk("wb_reqs", 64'({imem_req, dmem_req}), 64'd0);
    exp_instret++;
  endtask

  task automatic run_illegal(input logic [6:0] op);
    @(negedge clk);
    imem_ack = 1'b1;
    #1;
    chk("ill_fetch_ir_we", 64'(ir_we), 64'd1);
    chk("ill_instret", 64'(instret), 64'(exp_instret));
    @(negedge clk);
    imem_ack = 1'b0;
    opcode   = op;
    #1;
    chk("ill_decode_state", 64'(state), 64'(S_DECODE));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      imem_ack = rbit();
      dmem_ack = rbit();
      #1;
      chk("trap_imem_req", 64'(imem_req), 64'd0);
      chk("trap_state", 64'(state), 64'(S_TRAP));
    end
    chk("ill_flags", 64'({halt, illegal, bus_err}), 64'b110);
    chk("ill_strobes", 64'({ir_we, dmem_req, rf_we, pc_we}), 64'd0);
    chk("ill_instret_hold", 64'(instret), 64'(exp_instret));
  endtask

  logic [6:0] legal_ops [8];

  initial begin
    checks           = 0;
    failures         = 0;
    exp_instret      = 0;
    rst_n            = 1'b0;
    imem_ack         = 1'b0;
    dmem_ack         = 1'b0;
    opcode           = OP_R;
    writeback        = 1'b0;
    mem_write_enable = 1'b0;
    branch_taken     = 1'b0;
    legal_ops = '{OP_R, OP_I, OP_LUI, OP_JAL, OP_JALR, OP_S, OP_L, OP_B};
    repeat (3) @(negedge clk);
    do_reset();

    // ADD, LW/SW with 3-cycle data ack delay, branches, jumps.
    run_instr(OP_R, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    run_instr(OP_L, 1'b1, 1'b0, 1'b0, 0, 3, 0);
    run_instr(OP_S, 1'b1, 1'b1, 1'b0, 0, 3, 0);
    run_instr(OP_B, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    run_instr(OP_B, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    run_instr(OP_JALR, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    run_instr(OP_JAL, 1'b1, 1'b0, 1'b1, 1, 0, 0);
    run_instr(OP_LUI, 1'b1, 1'b0, 1'b0, 2, 0, 0);
    // Acks on the last accepted cycle still complete.
    run_instr(OP_I, 1'b1, 1'b0, 1'b0, TIMEOUT - 1, 0, 0);
    run_instr(OP_L, 1'b1, 1'b0, 1'b0, TIMEOUT - 1, TIMEOUT - 1, 0);

    for (int n = 0; n < 40; n++) begin
      run_instr(legal_ops[$urandom_range(0, 7)], rbit(), rbit(), rbit(),
                int'($urandom_range(0, TIMEOUT - 1)),
                int'($urandom_range(0, TIMEOUT - 1)), 0);
    end

    run_illegal(7'h7F);
    do_reset();

    // Reset mid-fetch drops the request at that edge.
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk("rfetch_req", 64'(imem_req), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rfetch_state", 64'(state), 64'(S_RESET));
    chk("rfetch_req_drop", 64'(imem_req), 64'd0);
    rst_n = 1'b1;

    run_instr(OP_R, 1'b1, 1'b0, 1'b0, 0, 0, 1);
    do_reset();
    run_instr(OP_L, 1'b1, 1'b0, 1'b0, 0, 0, 2);
    do_reset();
    run_instr(OP_S, 1'b0, 1'b1, 1'b0, 1, 1, 0);
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    chk("final_instret", 64'(instret), 64'd1);
    chk("final_state", 64'(state), 64'(S_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
